ahb_lite_fabric: RTL and testbench

- Parametrised AHB-Lite single-master interconnect for the data bus.
- Decodes the master address phase against a programmable base/mask map, registers the data-phase select, and muxes slave HRDATA/HREADYOUT/HRESP back to the master.
- Replaces fixed decoder/mux pairs with an N-slave fabric.
- Adds a built-in default slave that issues a proper two-cycle AHB ERROR on unmapped accesses, plus error logging and an interrupt.

---
 rtl/ahb_lite_fabric.sv | 187 ++++++++++++++++++
 tb/tb_ahb_lite_fabric.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_fabric.sv
// ahb_lite_fabric: single-master AHB-Lite interconnect for N slaves.
// Base/mask address decode, registered data-phase select, a response mux and a
// built-in default slave that answers unmapped accesses with a two-cycle ERROR.
// Optional feature (macro AHB_TIMEOUT_EN): a stall watchdog that turns a stuck
// slave into an ERROR and raises the extra tmo_flag output.
module ahb_lite_fabric #(
    parameter int                          NUM_SLAVES     = 4,
    parameter int                          ADDR_W         = 32,
    parameter int                          DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE      = {32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1C00_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK      = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000},
    parameter logic [DATA_W-1:0]           DEFAULT_RDATA  = 32'hDEAD_BEEF,
    parameter int                          TIMEOUT_CYCLES = 256
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    output logic [NUM_SLAVES-1:0]        HSEL_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
`ifdef AHB_TIMEOUT_EN
    output logic                         tmo_flag,
`endif
    output logic                         err_irq,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [7:0]                   err_count
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_SLAVE, SEL_NOMAP} sel_kind_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_e;

    sel_kind_e          sel_kind_d, sel_kind_q;
    logic [IDX_W-1:0]   sel_idx_d, sel_idx_q;
    logic [ADDR_W-1:0]  addr_d, addr_q;
    err_state_e         state_d, state_q;
    logic [ADDR_W-1:0]  err_addr_d, err_addr_q;
    logic [7:0]         err_count_d, err_count_q;
    logic               err_irq_d, err_irq_q;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               accept;
    logic               sel_ready;
    logic               log_err;

    // HWRITE and HTRANS[0] do not influence routing
    logic unused_inputs;
    assign unused_inputs = ^{HWRITE, HTRANS[0]};

`ifdef AHB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
    logic             tmo_flag_d, tmo_flag_q;
    logic             stall, tmo_hit;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Address decode: first matching window wins, not qualified by HTRANS
    always_comb begin
        HSEL_S  = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                hit       = 1'b1;
                hit_idx   = IDX_W'(i);
                HSEL_S[i] = 1'b1;
            end
        end
    end

    // Data-phase response mux; the default slave overrides any selected slave
    always_comb begin
        sel_ready = HREADYOUT_S[sel_idx_q];
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        if (state_q != ST_IDLE) begin
            HRDATA = DEFAULT_RDATA;
            HREADY = (state_q == ST_ERR2);
            HRESP  = 1'b1;
        end else if (sel_kind_q == SEL_SLAVE) begin
            HRDATA = HRDATA_S[sel_idx_q*DATA_W +: DATA_W];
            HREADY = sel_ready;
            HRESP  = HRESP_S[sel_idx_q];
        end
    end

    assign accept = HREADY & HTRANS[1];

`ifdef AHB_TIMEOUT_EN
    // Watchdog: count consecutive stall cycles of the selected slave
    always_comb begin
        stall     = (state_q == ST_IDLE) && (sel_kind_q == SEL_SLAVE) && !sel_ready;
        tmo_hit   = stall && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = '0;
        if (stall && !tmo_hit) tmo_cnt_d = tmo_cnt_q + 1'b1;
        tmo_flag_d = tmo_flag_q;
        if (tmo_hit)      tmo_flag_d = 1'b1;
        else if (err_clr) tmo_flag_d = 1'b0;
    end
    assign tmo_flag = tmo_flag_q;
`endif

    // Select capture, default-slave FSM and error logging next-state
    always_comb begin
        sel_kind_d  = sel_kind_q;
        sel_idx_d   = sel_idx_q;
        addr_d      = addr_q;
        state_d     = state_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        err_irq_d   = err_irq_q;

        if (HREADY) begin
            sel_kind_d = accept ? (hit ? SEL_SLAVE : SEL_NOMAP) : SEL_NONE;
            sel_idx_d  = hit_idx;
            addr_d     = HADDR;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && !hit) state_d = ST_ERR1;
`ifdef AHB_TIMEOUT_EN
                if (tmo_hit) state_d = ST_ERR1;
`endif
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = (accept && !hit) ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Logged at the end of ERR1 so a clear issued in ERR1 loses to the set
        log_err = (state_q == ST_ERR1);
        if (log_err) begin
            err_addr_d = addr_q;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            err_irq_d = 1'b1;
        end else if (err_clr) begin
            err_irq_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_kind_q  <= SEL_NONE;
            sel_idx_q   <= '0;
            addr_q      <= '0;
            state_q     <= ST_IDLE;
            err_addr_q  <= '0;
            err_count_q <= '0;
            err_irq_q   <= 1'b0;
`ifdef AHB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
`endif
        end else begin
            sel_kind_q  <= sel_kind_d;
            sel_idx_q   <= sel_idx_d;
            addr_q      <= addr_d;
            state_q     <= state_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            err_irq_q   <= err_irq_d;
`ifdef AHB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_flag_q  <= tmo_flag_d;
`endif
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
    assign err_irq   = err_irq_q;

endmodule

// File: tb/tb_ahb_lite_fabric.sv
// tb_ahb_lite_fabric: randomized self-checking bench for ahb_lite_fabric.
// A transaction-level master/slave model predicts every bus response and the
// error log; directed sequences cover the documented scenarios first.
module tb_ahb_lite_fabric;

    localparam int NS = 4;
    localparam logic [31:0] DEF_RDATA = 32'hDEAD_BEEF;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [NS-1:0]   HSEL_S;
    logic [NS*32-1:0] HRDATA_S;
    logic [NS-1:0]   HREADYOUT_S;
    logic [NS-1:0]   HRESP_S;
    logic [31:0]     HRDATA;
    logic            HREADY;
    logic            HRESP;
    logic            err_irq;
    logic            err_clr;
    logic [31:0]     err_addr;
    logic [7:0]      err_count;
`ifdef AHB_TIMEOUT_EN
    logic            tmo_flag;
`endif

    ahb_lite_fabric dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSEL_S      (HSEL_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
`ifdef AHB_TIMEOUT_EN
        .tmo_flag    (tmo_flag),
`endif
        .err_irq     (err_irq),
        .err_clr     (err_clr),
        .err_addr    (err_addr),
        .err_count   (err_count)
    );

    always #5 HCLK = ~HCLK;

    // Memory map as seen by the software view of the system
    logic [31:0] ref_base [NS] = '{32'h1C00_0000, 32'h1A10_1000, 32'h1A10_2000, 32'h1A10_3000};
    logic [31:0] ref_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

    typedef struct {
        logic [31:0] addr;
        logic        write;
        int          slave;
        int          waits;
        bit          err;
        logic [31:0] data;
        int          clr_k;
        int          idle_before;
    } txn_t;

    txn_t txq[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model state
    bit          dp_valid = 0;
    txn_t        dp;
    int          dp_k = 0;
    int          ai = 0;
    int          idle_left = 0;
    int          m_count = 0;
    logic [31:0] m_addr = '0;
    bit          m_irq = 0;
    logic        exp_ready, exp_resp;
    logic [31:0] exp_rdata;

    function automatic int ref_decode(logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & ref_mask[i]) == ref_base[i]) return i;
        return -1;
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic txn_t mkTxn(logic [31:0] addr, logic wr, int waits, logic [31:0] data, int clr_k, int idle);
        txn_t t;
        t.addr = addr; t.write = wr; t.slave = ref_decode(addr); t.waits = waits;
        t.err = 0; t.data = data; t.clr_k = clr_k; t.idle_before = idle;
        return t;
    endfunction

    function automatic txn_t makeRandomTxn();
        txn_t t;
        int r = $urandom_range(0, 4);
        logic [31:0] a;
        if (r < NS) a = ref_base[r] | ($urandom & ~ref_mask[r]);
        else        a = {4'h5, 28'($urandom)};
        t = mkTxn(a, 1'($urandom), $urandom_range(0, 3), $urandom, int'($urandom_range(0, 5)) - 1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        t.err = ($urandom_range(0, 7) == 0);
        return t;
    endfunction

    // Drive master and slave inputs for one cycle and predict the bus response
    task automatic applyStimulus();
        int s;
        logic rdy, rsp;
        if (ai < txq.size() && idle_left == 0) begin
            HADDR = txq[ai].addr; HTRANS = 2'b10; HWRITE = txq[ai].write;
        end else begin
            HADDR = $urandom; HTRANS = 2'($urandom_range(0, 1)); HWRITE = 1'($urandom);
        end
        for (int i = 0; i < NS; i++) begin
            HRDATA_S[i*32 +: 32] = $urandom;
            HREADYOUT_S[i] = 1'($urandom);
            HRESP_S[i] = 1'($urandom);
        end
        err_clr = 1'b0;
        exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = '0;
        if (dp_valid) begin
            if (dp.clr_k == dp_k) err_clr = 1'b1;
            if (dp.slave < 0) begin
                exp_ready = (dp_k == 1); exp_resp = 1'b1; exp_rdata = DEF_RDATA;
            end else begin
                s = dp.slave;
                if (dp.err) begin rdy = (dp_k == dp.waits + 1); rsp = (dp_k >= dp.waits); end
                else        begin rdy = (dp_k == dp.waits);     rsp = 1'b0; end
                HREADYOUT_S[s] = rdy; HRESP_S[s] = rsp;
                if (rdy && !dp.err) HRDATA_S[s*32 +: 32] = dp.data;
                exp_ready = rdy; exp_resp = rsp; exp_rdata = HRDATA_S[s*32 +: 32];
            end
        end
    endtask

    task automatic checkCycle();
        int d = ref_decode(HADDR);
        logic [31:0] exp_hsel = (d >= 0) ? (32'd1 << d) : 32'd0;
        checkOutput("hsel", 32'(HSEL_S), exp_hsel);
        checkOutput("hready", 32'(HREADY), 32'(exp_ready));
        checkOutput("hresp", 32'(HRESP), 32'(exp_resp));
        checkOutput("hrdata", HRDATA, exp_rdata);
        checkOutput("err_irq", 32'(err_irq), 32'(m_irq));
        checkOutput("err_addr", err_addr, m_addr);
        checkOutput("err_count", 32'(err_count), 32'(m_count));
    endtask

    // Advance the model across the coming clock edge
    task automatic advanceModel();
        if (dp_valid && dp.slave < 0 && dp_k == 0) begin
            if (m_count < 255) m_count++;
            m_addr = dp.addr;
            m_irq = 1;
        end else if (err_clr) begin
            m_irq = 0;
        end
        if (exp_ready) begin
            dp_valid = 0;
            if (ai < txq.size() && idle_left == 0) begin
                dp = txq[ai]; dp_valid = 1; dp_k = 0; ai++;
                if (ai < txq.size()) idle_left = txq[ai].idle_before;
            end else if (idle_left > 0) begin
                idle_left--;
            end
        end else begin
            dp_k++;
        end
    endtask

    task automatic runQueue();
        int cycles = 0;
        while ((ai < txq.size() || dp_valid) && cycles < 20000) begin
            @(posedge HCLK); #1;
            applyStimulus();
            @(negedge HCLK);
            checkCycle();
            advanceModel();
            cycles++;
        end
        if (cycles >= 20000) begin
            total_cnt++;
            $display("[TB] FAIL cycle_budget: got %0d cycles expected fewer than 20000", cycles);
        end
    endtask

    initial begin
        HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; err_clr = 1'b0;
        HRDATA_S = {NS{32'hA5A5_5A5A}}; HREADYOUT_S = '1; HRESP_S = '1;
        #12;
        checkOutput("rst_hready", 32'(HREADY), 32'd1);
        checkOutput("rst_hresp", 32'(HRESP), 32'd0);
        checkOutput("rst_hrdata", HRDATA, 32'd0);
        checkOutput("rst_err_irq", 32'(err_irq), 32'd0);
        checkOutput("rst_err_addr", err_addr, 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        @(negedge HCLK); HRESETn = 1'b1;

        // Slave0 read with two wait states, then write/read back-to-back
        txq.push_back(mkTxn(32'h1C00_0010, 1'b0, 2, 32'h1234_5678, -1, 0));
        txq.push_back(mkTxn(32'h1A10_2004, 1'b1, 0, 32'h0000_0000, -1, 1));
        txq.push_back(mkTxn(32'h1A10_3008, 1'b0, 1, 32'hCAFE_F00D, -1, 0));
        runQueue();

        // Single unmapped read
        txq.push_back(mkTxn(32'h5000_0000, 1'b0, 0, 32'h0, -1, 0));
        runQueue();
        checkOutput("first_err_count", 32'(err_count), 32'd1);
        checkOutput("first_err_addr", err_addr, 32'h5000_0000);

        // Back-to-back unmapped with clear during the second ERR1
        txq.push_back(mkTxn(32'h5000_0100, 1'b0, 0, 32'h0, -1, 0));
        txq.push_back(mkTxn(32'h5000_0200, 1'b0, 0, 32'h0, 0, 0));
        runQueue();
        checkOutput("b2b_err_count", 32'(err_count), 32'd3);
        checkOutput("b2b_irq_set_wins", 32'(err_irq), 32'd1);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++)
            txq.push_back(mkTxn({4'h5, 28'($urandom)}, 1'($urandom), 0, 32'h0, -1, 0));
        runQueue();
        checkOutput("sat_count", 32'(err_count), 32'd255);

        // Randomized traffic
        for (int i = 0; i < 400; i++) txq.push_back(makeRandomTxn());
        runQueue();

        // Reset asserted while the default slave is in ERR1
        @(posedge HCLK); #1;
        HADDR = 32'h5000_0040; HTRANS = 2'b10; err_clr = 1'b0;
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        @(negedge HCLK);
        checkOutput("mid_err1_hready", 32'(HREADY), 32'd0);
        HRESETn = 1'b0;
        #1;
        checkOutput("mid_rst_hready", 32'(HREADY), 32'd1);
        checkOutput("mid_rst_hresp", 32'(HRESP), 32'd0);
        checkOutput("mid_rst_hrdata", HRDATA, 32'd0);
        checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
        checkOutput("mid_rst_err_irq", 32'(err_irq), 32'd0);
        checkOutput("mid_rst_err_addr", err_addr, 32'd0);
        @(negedge HCLK); HRESETn = 1'b1;
        @(negedge HCLK);
        checkOutput("post_rst_hready", 32'(HREADY), 32'd1);
        checkOutput("post_rst_hresp", 32'(HRESP), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
